// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer for an external 1-bit ALU slice: walks an N-bit op LSB first,
// carrying the slice carry between steps and assembling the result.
module bit_serial_alu_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [1:0]   op_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout_o,
    output logic         ovf,
    output logic         alu_a,
    output logic         alu_b,
    output logic         alu_cin,
    output logic [1:0]   alu_op,
    input  logic         alu_s,
    input  logic         alu_cout
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic          msb_cin;
    logic [N-1:0]  a_r, b_r;
    logic [1:0]    op_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            msb_cin <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= 2'b00;
            result  <= '0;
            cout_o  <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a_in;
                        b_r   <= b_in;
                        op_r  <= op_in;
                        idx   <= '0;
                        // SUB seeds the +1 of A + ~B + 1; the slice inverts B itself
                        carry <= (op_in == 2'b11);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[idx] <= alu_s;
                    carry       <= alu_cout;
                    if (idx == LAST) begin
                        msb_cin <= carry;
                        // logic ops report no carry/overflow whatever the slice says
                        cout_o  <= op_r[1] & alu_cout;
                        ovf     <= op_r[1] & (carry ^ alu_cout);
                        done    <= 1'b1;
                        state   <= FIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        alu_a   = 1'b0;
        alu_b   = 1'b0;
        alu_cin = 1'b0;
        if (state == RUN) begin
            alu_a   = a_r[idx];
            alu_b   = b_r[idx];
            alu_cin = carry;
        end
    end

    assign alu_op = op_r;

    logic unused_msb_cin;
    assign unused_msb_cin = msb_cin;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench: a 1-bit slice model closes the loop; expected results are queued
// on accept and compared when done fires.
module tb_bit_serial_alu_ctrl;
    localparam int N = 8;

    logic         clk, rst_n, start;
    logic [N-1:0] a_in, b_in, result;
    logic [1:0]   op_in, alu_op;
    logic         busy, done, cout_o, ovf;
    logic         alu_a, alu_b, alu_cin, alu_s, alu_cout;

    bit_serial_alu_ctrl #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .busy(busy), .done(done), .result(result),
        .cout_o(cout_o), .ovf(ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_s(alu_s), .alu_cout(alu_cout)
    );

    // slice model; logic ops deliberately emit a carry to exercise flag masking
    always_comb begin
        logic bb;
        bb       = (alu_op == 2'b11) ? ~alu_b : alu_b;
        alu_s    = 1'b0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: begin alu_s = ~(alu_a | alu_b); alu_cout = alu_a & alu_b; end
            2'b01: begin alu_s = alu_a ^ alu_b;    alu_cout = alu_a & alu_b; end
            default: begin
                alu_s    = alu_a ^ bb ^ alu_cin;
                alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r;
        logic         c, v;
        logic [N-1:0] a, b;
        logic [1:0]   op;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;
    int   mcnt = 0, cyc = 0, last_done = 0;
    bit   b2b = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic [1:0] op, input int c);
        exp_t e;
        logic [N:0] s;
        e.a = a; e.b = b; e.op = op; e.acc = c; e.c = 1'b0; e.v = 1'b0;
        case (op)
            2'b00: e.r = ~(a | b);
            2'b01: e.r = a ^ b;
            2'b10: begin
                s = {1'b0, a} + {1'b0, b};
                e.r = s[N-1:0]; e.c = s[N];
                e.v = (a[N-1] == b[N-1]) && (e.r[N-1] != a[N-1]);
            end
            default: begin
                s = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
                e.r = s[N-1:0]; e.c = s[N];
                e.v = (a[N-1] != b[N-1]) && (e.r[N-1] != a[N-1]);
            end
        endcase
        return e;
    endfunction

    // acceptance model: idle only when mcnt==0; RUN is N cycles, FIN one
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt = 0;
            q.delete();
        end else begin
            cyc++;
            if (mcnt == 0) begin
                if (start) begin
                    q.push_back(model(a_in, b_in, op_in, cyc));
                    mcnt = N + 1;
                end
            end else begin
                mcnt--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            int   i;
            chk("busy", busy, mcnt != 0);
            chk("done", done, mcnt == 1);
            if (mcnt >= 2) begin
                e = q[0];
                i = N + 1 - mcnt;
                chk("alu_a", alu_a, e.a[i]);
                chk("alu_b", alu_b, e.b[i]);
                chk("alu_op", alu_op, e.op);
                if (i == 0) chk("cin0", alu_cin, e.op == 2'b11);
            end else begin
                chk("alu_idle", {alu_a, alu_b, alu_cin}, 3'b000);
            end
            if (mcnt == 1 && q.size() != 0) begin
                e = q.pop_front();
                chk("result", result, e.r);
                chk("cout", cout_o, e.c);
                chk("ovf", ovf, e.v);
                chk("latency", cyc - e.acc + 1, N + 1);
                if (b2b && last_done > 0) chk("b2b_gap", cyc - last_done, N + 2);
                last_done = cyc;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (mcnt != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("timeout", mcnt != 0, 1'b0);
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
        @(negedge clk);
        a_in = a; b_in = b; op_in = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, {result, cout_o, ovf, busy, done, alu_a, alu_b, alu_cin, alu_op}, '0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; op_in = 2'b00;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        #2 rst_n = 1'b1;

        do_op(8'h7F, 8'h01, 2'b10);
        do_op(8'h05, 8'h07, 2'b11);
        do_op(8'h80, 8'h01, 2'b11);
        do_op(8'hF0, 8'h0F, 2'b00);
        do_op(8'hAA, 8'hFF, 2'b01);
        do_op(8'h00, 8'h00, 2'b00);

        // start pulses during RUN must be ignored
        @(negedge clk);
        a_in = 8'hFF; b_in = 8'h01; op_in = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a_in = 8'h05; b_in = 8'h07; op_in = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset in the middle of RUN aborts with no done
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; op_in = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("mid_reset");
        repeat (2) @(negedge clk);
        chk_reset_outs("held_reset");
        #2 rst_n = 1'b1;
        do_op(8'h12, 8'h34, 2'b10);

        // start held high: back-to-back accepts every N+2 cycles
        b2b = 1'b1;
        last_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 4 * (N + 2) + 2; i++) begin
            a_in  = N'($urandom);
            b_in  = N'($urandom);
            op_in = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        b2b = 1'b0;

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
